// File: rtl/powerlink_led_sequencer.sv
// rtl/powerlink_led_sequencer.sv - status/error LED pattern sequencer driving a PIO through set/clear writes
module powerlink_led_sequencer #(
    parameter int TICK_CYCLES = 2500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  s_address,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    input  logic        s_read,
    output logic [31:0] s_readdata,
    output logic [2:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_SET,
        ST_CLR
    } state_t;

    logic [CW-1:0] tick_cnt;
    logic          tick;
    logic [2:0]    status_mode;
    logic [2:0]    error_mode;
    logic [5:0]    status_phase;
    logic [5:0]    error_phase;
    logic [1:0]    desired;
    logic [1:0]    applied;
    logic [1:0]    applied_next;
    logic [1:0]    set_bits;
    logic [1:0]    set_bits_next;
    logic [1:0]    clr_bits;
    logic [1:0]    clr_bits_next;
    state_t        state;
    state_t        state_next;
    // bus_rest forces one cycle with chipselect low; also holds the bus quiet
    // through reset so the INIT write starts only after release.
    logic          bus_rest;
    logic          bus_rest_next;

    // Upper write-data bits carry no configuration.
    logic          unused_wdata;
    assign unused_wdata = ^s_writedata[31:3];

    // Last phase value of each mode's period; steady modes sit at phase 0.
    function automatic logic [5:0] phase_last(input logic [2:0] mode);
        logic [5:0] last;
        last = 6'd0;
        case (mode)
            3'd2:    last = 6'd1;
            3'd3:    last = 6'd7;
            3'd4:    last = 6'd23;
            3'd5:    last = 6'd31;
            3'd6:    last = 6'd39;
            default: last = 6'd0;
        endcase
        return last;
    endfunction

    // Next phase on a tick: advance, wrapping after the period's last phase.
    function automatic logic [5:0] phase_step(input logic [2:0] mode, input logic [5:0] phase);
        return (phase >= phase_last(mode)) ? 6'd0 : phase + 6'd1;
    endfunction

    // LED level for a given mode at a given phase; mode 7 is treated as off.
    function automatic logic led_on(input logic [2:0] mode, input logic [5:0] phase);
        logic on;
        on = 1'b0;
        case (mode)
            3'd1:    on = 1'b1;
            3'd2:    on = (phase == 6'd0);
            3'd3:    on = (phase < 6'd4);
            3'd4:    on = (phase < 6'd4);
            3'd5:    on = (phase < 6'd4) || (phase >= 6'd8 && phase < 6'd12);
            3'd6:    on = (phase < 6'd4) || (phase >= 6'd8 && phase < 6'd12) ||
                          (phase >= 6'd16 && phase < 6'd20);
            default: on = 1'b0;
        endcase
        return on;
    endfunction

    assign tick = (tick_cnt == TICK_LAST);

    // Free-running pattern tick counter, one tick per TICK_CYCLES clocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CW'(1);
        end
    end

    // Mode registers and per-LED phase counters; a config write restarts its LED's pattern and beats a tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            status_mode  <= 3'd0;
            error_mode   <= 3'd0;
            status_phase <= 6'd0;
            error_phase  <= 6'd0;
        end else begin
            if (tick) begin
                status_phase <= phase_step(status_mode, status_phase);
                error_phase  <= phase_step(error_mode, error_phase);
            end
            if (s_write && s_address == 2'd0) begin
                status_mode  <= s_writedata[2:0];
                status_phase <= 6'd0;
            end
            if (s_write && s_address == 2'd1) begin
                error_mode  <= s_writedata[2:0];
                error_phase <= 6'd0;
            end
        end
    end

    // Registered desired LED vector: bit0 status, bit1 error.
    always_ff @(posedge clk) begin
        if (reset) begin
            desired <= 2'b00;
        end else begin
            desired <= {led_on(error_mode, error_phase), led_on(status_mode, status_phase)};
        end
    end

    // Config read port: data one cycle after the strobe, held otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_readdata <= 32'd0;
        end else if (s_read) begin
            case (s_address)
                2'd0:    s_readdata <= {29'd0, status_mode};
                2'd1:    s_readdata <= {29'd0, error_mode};
                2'd2:    s_readdata <= {30'd0, applied};
                default: s_readdata <= 32'd0;
            endcase
        end
    end

    // Master FSM state, committed LED value and latched set/clear masks.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_INIT;
            bus_rest <= 1'b1;
            applied  <= 2'b00;
            set_bits <= 2'b00;
            clr_bits <= 2'b00;
        end else begin
            state    <= state_next;
            bus_rest <= bus_rest_next;
            applied  <= applied_next;
            set_bits <= set_bits_next;
            clr_bits <= clr_bits_next;
        end
    end

    // Master FSM next state and bus outputs; a write completes when waitrequest is low.
    always_comb begin
        state_next    = state;
        bus_rest_next = 1'b0;
        applied_next  = applied;
        set_bits_next = set_bits;
        clr_bits_next = clr_bits;
        m_chipselect  = 1'b0;
        m_write_n     = 1'b1;
        m_address     = 3'd0;
        m_writedata   = 32'd0;
        if (!bus_rest) begin
            case (state)
                ST_INIT: begin
                    m_chipselect = 1'b1;
                    m_write_n    = 1'b0;
                    if (!m_waitrequest) begin
                        applied_next = 2'b00;
                        state_next   = ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if ((desired & ~applied) != 2'b00) begin
                        set_bits_next = desired & ~applied;
                        clr_bits_next = ~desired & applied;
                        state_next    = ST_SET;
                    end else if ((~desired & applied) != 2'b00) begin
                        set_bits_next = 2'b00;
                        clr_bits_next = ~desired & applied;
                        state_next    = ST_CLR;
                    end
                end
                ST_SET: begin
                    m_chipselect = 1'b1;
                    m_write_n    = 1'b0;
                    m_address    = 3'd4;
                    m_writedata  = {30'd0, set_bits};
                    if (!m_waitrequest) begin
                        applied_next = applied | set_bits;
                        if (clr_bits != 2'b00) begin
                            state_next    = ST_CLR;
                            bus_rest_next = 1'b1;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end
                end
                ST_CLR: begin
                    m_chipselect = 1'b1;
                    m_write_n    = 1'b0;
                    m_address    = 3'd5;
                    m_writedata  = {30'd0, clr_bits};
                    if (!m_waitrequest) begin
                        applied_next = applied & ~clr_bits;
                        state_next   = ST_IDLE;
                    end
                end
                default: state_next = ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_powerlink_led_sequencer.sv
// tb/tb_powerlink_led_sequencer.sv - scoreboard bench for powerlink_led_sequencer
module tb_powerlink_led_sequencer;

    localparam int TICK = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  s_address;
    logic        s_write;
    logic [31:0] s_writedata;
    logic        s_read;
    logic [31:0] s_readdata;
    logic [2:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic        m_waitrequest;

    typedef struct packed {
        logic [2:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  done_cyc[$];
    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  tcnt = 0;
    int  pushed = 0;
    int  seen = 0;

    powerlink_led_sequencer #(.TICK_CYCLES(TICK)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_address    (s_address),
        .s_write      (s_write),
        .s_writedata  (s_writedata),
        .s_read       (s_read),
        .s_readdata   (s_readdata),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write_n    (m_write_n),
        .m_writedata  (m_writedata),
        .m_waitrequest(m_waitrequest)
    );

    always #5 clk = ~clk;

    // Cycle index and reference tick counter.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) tcnt <= 0;
        else tcnt <= (tcnt == TICK - 1) ? 0 : tcnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Completed master writes are popped against the expected queue.
    always @(negedge clk) begin
        if (!reset && m_chipselect && !m_write_n && !m_waitrequest) begin
            seen++;
            done_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("spurious_wr", seen, pushed);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", {29'd0, m_address}, {29'd0, e.addr});
                chk("wr_data", m_writedata, e.data);
            end
        end
    end

    task automatic push(input logic [2:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
        pushed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_cfg(input logic [1:0] a, input logic [31:0] d);
        s_address   = a;
        s_writedata = d;
        s_write     = 1'b1;
        step();
        s_write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        s_address = a;
        s_read    = 1'b1;
        step();
        s_read = 1'b0;
        chk(tag, s_readdata, exp);
    endtask

    task automatic drain(input int budget, input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_cs(input int budget, output int k);
        int n;
        n = 0;
        while (!m_chipselect && n < budget) begin
            step();
            n++;
        end
        chk("cs_seen", {31'd0, m_chipselect}, 32'd1);
        k = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int w;
        int offs[8];
        offs = '{3, 7, 9, 11, 13, 15, 17, 19};
        reset         = 1'b1;
        s_address     = 2'd0;
        s_write       = 1'b0;
        s_writedata   = 32'd0;
        s_read        = 1'b0;
        m_waitrequest = 1'b0;
        step();
        step();
        chk("rst_cs", {31'd0, m_chipselect}, 32'd0);
        chk("rst_wn", {31'd0, m_write_n}, 32'd1);
        chk("rst_addr", {29'd0, m_address}, 32'd0);
        chk("rst_wdata", m_writedata, 32'd0);
        chk("rst_rdata", s_readdata, 32'd0);
        push(3'd0, 32'd0);
        reset = 1'b0;
        drain(10, "init_drain");
        repeat (10) step();
        rd(2'd0, 32'd0, "rd_status_rst");
        rd(2'd1, 32'd0, "rd_error_rst");
        rd(2'd2, 32'd0, "rd_applied_rst");
        wr_cfg(2'd2, 32'd3);
        wr_cfg(2'd3, 32'd1);
        rd(2'd2, 32'd0, "ro_applied");
        rd(2'd3, 32'd0, "rd_addr3");
        repeat (6) step();

        // Steady on, then off.
        push(3'd4, 32'd1);
        wr_cfg(2'd0, 32'd1);
        drain(20, "on_drain");
        rd(2'd2, 32'd1, "applied_on");
        rd(2'd0, 32'd1, "status_rb");
        repeat (20) step();
        chk("rd_hold", s_readdata, 32'd1);
        push(3'd5, 32'd1);
        wr_cfg(2'd0, 32'd0);
        drain(20, "off_drain");
        rd(2'd2, 32'd0, "applied_off");

        // Error flicker.
        done_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            push(3'd4, 32'd2);
            push(3'd5, 32'd2);
        end
        wr_cfg(2'd1, 32'd2);
        drain(100, "flk_drain");
        wr_cfg(2'd1, 32'd0);
        chk("flk_count", done_cyc.size(), 8);
        if (done_cyc.size() >= 8) begin
            chk("flk_period1", done_cyc[4] - done_cyc[2], 8);
            chk("flk_period2", done_cyc[6] - done_cyc[4], 8);
            chk("flk_on1", done_cyc[3] - done_cyc[2], 4);
            chk("flk_on2", done_cyc[7] - done_cyc[6], 4);
        end
        repeat (20) step();
        rd(2'd2, 32'd0, "flk_applied_off");

        // Status double flash over two periods.
        done_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            push(3'd4, 32'd1);
            push(3'd5, 32'd1);
        end
        wr_cfg(2'd0, 32'd5);
        drain(400, "dbl_drain");
        wr_cfg(2'd0, 32'd0);
        chk("dbl_count", done_cyc.size(), 8);
        if (done_cyc.size() >= 8) begin
            chk("dbl_gap", done_cyc[2] - done_cyc[1], 16);
            chk("dbl_on2", done_cyc[3] - done_cyc[2], 16);
            chk("dbl_tail", done_cyc[4] - done_cyc[3], 80);
            chk("dbl_second", done_cyc[6] - done_cyc[4], 32);
            chk("dbl_on4", done_cyc[7] - done_cyc[6], 16);
            chk("dbl_period", done_cyc[6] - done_cyc[2], 128);
        end
        repeat (10) step();

        // Stalled set write while the LED is turned off again.
        done_cyc.delete();
        m_waitrequest = 1'b1;
        wr_cfg(2'd0, 32'd1);
        wait_cs(10, k);
        chk("ws_addr", {29'd0, m_address}, 32'd4);
        chk("ws_data", m_writedata, 32'd1);
        wr_cfg(2'd0, 32'd0);
        rd(2'd2, 32'd0, "ws_applied_stall");
        for (int i = 0; i < 3; i++) begin
            chk("ws_hold_cs", {31'd0, m_chipselect}, 32'd1);
            chk("ws_hold_addr", {29'd0, m_address}, 32'd4);
            chk("ws_hold_data", m_writedata, 32'd1);
            step();
        end
        push(3'd4, 32'd1);
        push(3'd5, 32'd1);
        m_waitrequest = 1'b0;
        step();
        chk("ws_idle_gap", {31'd0, m_chipselect}, 32'd0);
        rd(2'd2, 32'd1, "ws_applied_done");
        drain(10, "ws_drain");
        if (done_cyc.size() >= 2) begin
            chk("ws_done_cycle", done_cyc[0], k + 5);
            chk("ws_clr_cycle", done_cyc[1] - done_cyc[0], 2);
        end else begin
            chk("ws_count", done_cyc.size(), 2);
        end
        rd(2'd2, 32'd0, "ws_applied_final");

        // Anti-phase flicker: status write coincides with a tick, error one tick later.
        repeat (10) step();
        done_cyc.delete();
        push(3'd4, 32'd1);
        push(3'd4, 32'd2);
        push(3'd5, 32'd1);
        push(3'd4, 32'd1);
        push(3'd5, 32'd2);
        push(3'd4, 32'd2);
        push(3'd5, 32'd1);
        push(3'd5, 32'd2);
        k = 0;
        while (tcnt != TICK - 1 && k < 8) begin
            step();
            k++;
        end
        w = cyc;
        wr_cfg(2'd0, 32'd2);
        repeat (3) step();
        wr_cfg(2'd1, 32'd2);
        while (cyc < w + 12) step();
        wr_cfg(2'd0, 32'd0);
        wr_cfg(2'd1, 32'd0);
        drain(40, "sim_drain");
        chk("sim_count", done_cyc.size(), 8);
        if (done_cyc.size() >= 8) begin
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("sim_t%0d", i), done_cyc[i] - w, offs[i]);
            end
        end
        repeat (10) step();

        // Mode 7 acts as off.
        push(3'd4, 32'd1);
        wr_cfg(2'd0, 32'd1);
        drain(20, "m7_on_drain");
        push(3'd5, 32'd1);
        wr_cfg(2'd0, 32'd7);
        drain(20, "m7_drain");
        repeat (40) step();
        rd(2'd0, 32'd7, "m7_rb");
        rd(2'd2, 32'd0, "m7_applied");
        wr_cfg(2'd0, 32'd0);
        repeat (10) step();

        // Reset during a stalled SET write.
        m_waitrequest = 1'b1;
        wr_cfg(2'd0, 32'd1);
        wait_cs(10, k);
        chk("rs_addr", {29'd0, m_address}, 32'd4);
        reset = 1'b1;
        step();
        chk("rs_cs", {31'd0, m_chipselect}, 32'd0);
        chk("rs_wn", {31'd0, m_write_n}, 32'd1);
        chk("rs_maddr", {29'd0, m_address}, 32'd0);
        chk("rs_wdata", m_writedata, 32'd0);
        m_waitrequest = 1'b0;
        step();
        push(3'd0, 32'd0);
        reset = 1'b0;
        drain(10, "rs_init_drain");
        repeat (10) step();
        rd(2'd0, 32'd0, "rs_status");
        rd(2'd2, 32'd0, "rs_applied");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/powerlink_led_sequencer.md
POWERLINK_LED_SEQUENCER -- requirements
Module: powerlink_led_sequencer

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 2500000, clock cycles per 50 ms pattern tick (50 MHz clk).
REQ-002 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port s_address  in  2  config slave register select.
REQ-005 SHALL have port s_write  in  1  config write strobe, single cycle, no wait states.
REQ-006 SHALL have port s_writedata  in  32  config write data.
REQ-007 SHALL have port s_read  in  1  config read strobe.
REQ-008 SHALL have port s_readdata  out  32  config read data.
REQ-009 SHALL have port m_address  out  3  LED PIO register address (0 data, 4 set-bits, 5 clear-bits).
REQ-010 SHALL have port m_chipselect  out  1  LED PIO select.
REQ-011 SHALL have port m_write_n  out  1  LED PIO write, active-low.
REQ-012 SHALL have port m_writedata  out  32  LED PIO write data; bit0 status LED, bit1 error LED, bits[31:2] always 0.
REQ-013 SHALL have port m_waitrequest  in  1  stretches the current master write while high; tie 0 for the zero-wait PIO.

Function
REQ-014 SHALL decode slave address 0 as STATUS_MODE and 1 as ERROR_MODE: 3-bit mode fields, written from s_writedata[2:0].
REQ-015 SHALL decode slave address 2 as APPLIED (read-only): last LED value committed to the PIO.
REQ-016 SHALL ignore writes to addresses 2 and 3; reads of address 3 SHALL return 0.
REQ-017 SHALL return s_readdata one cycle after s_read, zero-extended; s_readdata holds its value when s_read is low.
REQ-018 SHALL implement a tick counter 0..TICK_CYCLES-1 that wraps and pulses tick for one cycle at the terminal count.
REQ-019 SHALL keep one 6-bit phase counter per LED; each advances on tick and wraps to 0 after period-1.
REQ-020 SHALL use these modes (on-phases inclusive): 0 off; 1 on; 2 flicker, period 2, on 0; 3 blink, period 8, on 0-3; 4 single flash, period 24, on 0-3; 5 double flash, period 32, on 0-3 and 8-11; 6 triple flash, period 40, on 0-3, 8-11 and 16-19; 7 behaves as off.
REQ-021 SHALL clear the addressed LED's phase counter on a config write; if a write and a tick coincide, the write wins (phase = 0).
REQ-022 SHALL register the desired LED vector, so it reflects mode and phase with 1-cycle latency.
REQ-023 SHALL use a master FSM with states INIT, IDLE, SET, CLR.
REQ-024 SHALL leave INIT for IDLE once it has written address 0 with data 0.
REQ-025 SHALL, in IDLE, go to SET when desired & ~applied is nonzero; otherwise to CLR when ~desired & applied is nonzero; otherwise stay in IDLE.
REQ-026 SHALL, in SET, write address 4 with the latched set-bits, then go to CLR if the latched clear-bits are nonzero, else to IDLE.
REQ-027 SHALL, in CLR, write address 5 with the latched clear-bits, then go to IDLE.
REQ-028 SHALL latch set-bits and clear-bits on leaving IDLE; desired changes during SET/CLR SHALL NOT alter an in-flight write and SHALL be re-evaluated in IDLE.
REQ-029 SHALL drive master writes as m_chipselect=1 and m_write_n=0 with stable address and data, held while m_waitrequest=1.
REQ-030 SHALL complete a master write in the cycle m_waitrequest=0 and update applied in that cycle (OR set-bits, AND ~clear-bits, or load 0 for INIT).
REQ-031 SHALL drive m_chipselect=0, m_write_n=1, m_address=0 and m_writedata=0 outside active writes.
REQ-032 SHALL start consecutive master writes no sooner than one idle cycle (m_chipselect=0) apart.

Reset
REQ-033 SHALL, when reset is high on a rising edge, clear both modes, both phases, the tick counter, applied, desired and s_readdata to 0.
REQ-034 SHALL, on the same reset edge, set FSM=INIT, m_chipselect=0, m_write_n=1, m_address=0 and m_writedata=0.
REQ-035 SHALL apply reset mid-write by aborting the write immediately, without completing it; the INIT write follows reset release.

Verification (TICK_CYCLES=4, m_waitrequest=0 unless stated)
REQ-036 SHALL cover reset release: one write addr 0 data 0 follows, then idle bus; reads of addresses 0, 1 and 2 return 0.
REQ-037 SHALL cover STATUS_MODE=1: one write addr 4 data 1; APPLIED reads 1; no further writes.
REQ-038 SHALL cover ERROR_MODE=2 (flicker): addr 4 data 2 and addr 5 data 2 alternate, one pair per 8 cycles (4 on, 4 off).
REQ-039 SHALL cover STATUS_MODE=5 (double flash): bit0 on for ticks 0-3 and 8-11, off for the rest of each 32-tick (128-cycle) period.
REQ-040 SHALL cover an on-to-off change while m_waitrequest=1 for 5 cycles: address and data are held stable, applied updates on the completion cycle, and the clear write follows after an idle cycle.
REQ-041 SHALL cover simultaneous events: a config write coincident with tick forces phase 0; mode 7 behaves as off; reset asserted during SET aborts the write and is followed by the INIT write.
